// File: rtl/csr_rmw_unit_if.sv
// csr_rmw_unit_if
//   Bundles the uop issue, CSR read, writeback, commit/squash and CSR write
//   signals of csr_rmw_unit. clk/rst are not part of the interface.
//   slave  : the csr_rmw_unit side (drives o_*).
//   master : the surrounding pipeline / CSR file side (drives i_*).
interface csr_rmw_unit_if #(
    parameter int XLEN     = 64,
    parameter int ROBIDX_W = 6
);
    // uop issue
    logic                i_valid;
    logic                o_ready;
    logic [1:0]          i_op;
    logic                i_use_imm;
    logic [XLEN-1:0]     i_src;
    logic [4:0]          i_imm;
    logic                i_rs1_zero;
    logic [11:0]         i_csrIdx;
    logic [ROBIDX_W-1:0] i_robIdx;
    // CSR read
    logic                o_access;
    logic [11:0]         o_read_csrIdx;
    logic                i_read_illegal;
    logic [XLEN-1:0]     i_read_val;
    // writeback
    logic                o_wb_valid;
    logic                i_wb_ready;
    logic [ROBIDX_W-1:0] o_wb_robIdx;
    logic [XLEN-1:0]     o_wb_val;
    logic                o_wb_illegal;
    // commit / flush
    logic                i_commit_valid;
    logic [ROBIDX_W-1:0] i_commit_robIdx;
    logic                i_squash;
    // CSR write
    logic                o_write;
    logic [11:0]         o_write_csrIdx;
    logic [XLEN-1:0]     o_write_val;

    modport slave (
        input  i_valid, i_op, i_use_imm, i_src, i_imm, i_rs1_zero, i_csrIdx, i_robIdx,
        input  i_read_illegal, i_read_val, i_wb_ready,
        input  i_commit_valid, i_commit_robIdx, i_squash,
        output o_ready, o_access, o_read_csrIdx,
        output o_wb_valid, o_wb_robIdx, o_wb_val, o_wb_illegal,
        output o_write, o_write_csrIdx, o_write_val
    );

    modport master (
        output i_valid, i_op, i_use_imm, i_src, i_imm, i_rs1_zero, i_csrIdx, i_robIdx,
        output i_read_illegal, i_read_val, i_wb_ready,
        output i_commit_valid, i_commit_robIdx, i_squash,
        input  o_ready, o_access, o_read_csrIdx,
        input  o_wb_valid, o_wb_robIdx, o_wb_val, o_wb_illegal,
        input  o_write, o_write_csrIdx, o_write_val
    );
endinterface

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit
//   Executes csrrw/csrrs/csrrc (and immediate forms), one at a time:
//   accept -> CSR read -> writeback of old value -> wait for commit ->
//   single-cycle CSR write.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   bus (slave)     issue / CSR read / writeback / commit+squash / CSR write
//   o_stall_cnt     32-bit saturating count of cycles with i_valid && !o_ready
//                   (only when CSR_RMW_STALL_CNT_EN is defined)
// Optional feature macro: CSR_RMW_STALL_CNT_EN
module csr_rmw_unit #(
    parameter int XLEN     = 64,
    parameter int ROBIDX_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    csr_rmw_unit_if.slave bus
`ifdef CSR_RMW_STALL_CNT_EN
    ,
    output logic [31:0]   o_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WB,
        WAIT_COMMIT,
        WRITE
    } state_t;

    typedef enum logic [1:0] {
        OP_ILL = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } op_t;

    state_t              state, state_n;

    // latched uop
    op_t                 op_q;
    logic [XLEN-1:0]     opnd_q;
    logic [11:0]         idx_q;
    logic [ROBIDX_W-1:0] rob_q;
    logic                rs1_zero_q;

    // results captured in READ
    logic [XLEN-1:0]     old_q;
    logic [XLEN-1:0]     new_q;
    logic                illegal_q;
    logic                need_write_q;

    logic                ready_c;
    logic                access_c;
    logic                wb_valid_c;
    logic                write_c;
    logic                accept;
    logic                commit_hit;

    logic                need_write_c;
    logic                illegal_c;
    logic [XLEN-1:0]     new_c;

    // A squash in IDLE drops the offered uop even though o_ready is high.
    assign accept     = bus.i_valid && ready_c && !bus.i_squash;
    assign commit_hit = bus.i_commit_valid && (bus.i_commit_robIdx == rob_q);

    // Read-cycle evaluation of the RMW result and legality.
    always_comb begin
        need_write_c = (op_q == OP_RW) || !rs1_zero_q;
        illegal_c    = bus.i_read_illegal || (op_q == OP_ILL) ||
                       (need_write_c && (idx_q[11:10] == 2'b11));
        case (op_q)
            OP_RW:   new_c = opnd_q;
            OP_RS:   new_c = bus.i_read_val | opnd_q;
            OP_RC:   new_c = bus.i_read_val & ~opnd_q;
            default: new_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        ready_c    = 1'b0;
        access_c   = 1'b0;
        wb_valid_c = 1'b0;
        write_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (accept) state_n = READ;
            end
            READ: begin
                access_c = 1'b1;
                state_n  = bus.i_squash ? IDLE : WB;
            end
            WB: begin
                wb_valid_c = 1'b1;
                // squash beats a same-cycle handshake
                if (bus.i_squash) begin
                    state_n = IDLE;
                end else if (bus.i_wb_ready) begin
                    state_n = (illegal_q || !need_write_q) ? IDLE : WAIT_COMMIT;
                end
            end
            WAIT_COMMIT: begin
                // matching commit beats a same-cycle squash
                if (commit_hit) begin
                    state_n = WRITE;
                end else if (bus.i_squash) begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                write_c = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OP_ILL;
            opnd_q       <= '0;
            idx_q        <= '0;
            rob_q        <= '0;
            rs1_zero_q   <= 1'b0;
            old_q        <= '0;
            new_q        <= '0;
            illegal_q    <= 1'b0;
            need_write_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= op_t'(bus.i_op);
                opnd_q     <= bus.i_use_imm ? {{(XLEN-5){1'b0}}, bus.i_imm} : bus.i_src;
                idx_q      <= bus.i_csrIdx;
                rob_q      <= bus.i_robIdx;
                rs1_zero_q <= bus.i_rs1_zero;
            end
            if (state == READ) begin
                old_q        <= bus.i_read_val;
                new_q        <= new_c;
                illegal_q    <= illegal_c;
                need_write_q <= need_write_c;
            end
        end
    end

    assign bus.o_ready        = ready_c;
    assign bus.o_access       = access_c;
    assign bus.o_read_csrIdx  = idx_q;
    assign bus.o_wb_valid     = wb_valid_c;
    assign bus.o_wb_robIdx    = rob_q;
    assign bus.o_wb_val       = illegal_q ? '0 : old_q;
    assign bus.o_wb_illegal   = wb_valid_c && illegal_q;
    assign bus.o_write        = write_c;
    assign bus.o_write_csrIdx = idx_q;
    assign bus.o_write_val    = new_q;

`ifdef CSR_RMW_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stall_cnt <= '0;
        end else if (bus.i_valid && !ready_c && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/csr_rmw_unit.md
Name: csr_rmw_unit

Overview:
- Executes CSR instructions (csrrw/csrrs/csrrc and immediate forms) for the backend, directly upstream of the privilege/CSR file.
- Issues the CSR read, computes the read-modify-write value and writes back the old value to the register file/ROB.
- Holds the CSR write until the instruction commits, then drives a single-cycle write into the CSR file.
- Exactly one CSR instruction is in flight at a time.

Parameters:
- XLEN, 64, data width of CSR and GPR values.
- ROBIDX_W, 6, ROB index width.

Ports:
- clk  in  1  clock (already decided).
- rst  in  1  reset: synchronous, active-high (already decided).
- i_valid  in  1  CSR uop offered.
- o_ready  out  1  unit idle; uop accepted when i_valid && o_ready.
- i_op  in  2  operation: 01 RW, 10 RS (set), 11 RC (clear); 00 is illegal.
- i_use_imm  in  1  operand is zero-extended i_imm instead of i_src.
- i_src  in  XLEN  rs1 value.
- i_imm  in  5  uimm field.
- i_rs1_zero  in  1  rs1 field is x0, or uimm == 0.
- i_csrIdx  in  12  CSR address.
- i_robIdx  in  ROBIDX_W  ROB tag.
- o_access  out  1  CSR read strobe.
- o_read_csrIdx  out  12  CSR read address.
- i_read_illegal  in  1  read privilege violation, same cycle as o_access.
- i_read_val  in  XLEN  CSR read data, same cycle as o_access.
- o_wb_valid  out  1  writeback valid.
- i_wb_ready  in  1  writeback accepted.
- o_wb_robIdx  out  ROBIDX_W  writeback tag.
- o_wb_val  out  XLEN  old CSR value; 0 if illegal.
- o_wb_illegal  out  1  raise illegal-instruction exception.
- i_commit_valid  in  1  ROB commit strobe.
- i_commit_robIdx  in  ROBIDX_W  committing tag.
- i_squash  in  1  pipeline flush.
- o_write  out  1  CSR write strobe (one cycle).
- o_write_csrIdx  out  12  CSR write address.
- o_write_val  out  XLEN  CSR write data.

Behaviour:
- **Reset values:** state IDLE; o_ready=1; o_access, o_wb_valid, o_wb_illegal, o_write = 0; all data outputs 0.
- **States:** IDLE, READ, WB, WAIT_COMMIT, WRITE.
- **IDLE:** o_ready=1. On accept, latch op, operand, idx, robIdx, rs1_zero, then go to READ. Operand = use_imm ? zext(imm) : src.
- **READ (one cycle):**
  - o_access=1 and o_read_csrIdx=latched idx.
  - Sample i_read_val and i_read_illegal.
  - need_write = (op==RW) || !rs1_zero.
  - illegal = i_read_illegal || op==00 || (need_write && idx[11:10]==2'b11).
  - new value: RW → opnd; RS → old | opnd; RC → old & ~opnd.
  - Go to WB.
- **WB:**
  - o_wb_valid=1 until i_wb_ready.
  - o_wb_val = illegal ? 0 : old; o_wb_illegal = illegal.
  - On handshake: if illegal or !need_write go to IDLE, else go to WAIT_COMMIT.
- **WAIT_COMMIT:**
  - i_commit_valid && i_commit_robIdx == latched tag → WRITE.
  - A commit of any other tag is ignored.
- **WRITE (exactly one cycle):** o_write=1 with latched idx and new value, then IDLE. o_ready rises the following cycle.
- **Latency:** accept to o_wb_valid = 2 cycles. Matching commit to o_write = 1 cycle.
- **Squash:**
  - In READ, WB or WAIT_COMMIT: the next state is IDLE, with no writeback and no write. A squash in READ suppresses the WB; o_access in that cycle is harmless.
  - In WRITE: the squash is ignored and the write completes.
  - In IDLE: nothing is accepted that cycle (o_ready may stay 1, but i_valid is dropped).
- **Simultaneous events:**
  - Matching commit and squash in the same WAIT_COMMIT cycle: commit wins, go to WRITE.
  - Squash and wb handshake in the same cycle: squash wins, the write is never performed.
- **Mid-operation reset:** rst forces IDLE and all outputs to reset values in any state.
- **Write-data rule:** o_write_val is written verbatim; the CSR file applies field masking.

Optional Feature:
- Macro: CSR_RMW_STALL_CNT_EN.
- **With the macro:**
  - Adds output o_stall_cnt, 32 bits.
  - Increments every cycle with i_valid && !o_ready.
  - Cleared by rst and saturates at all-ones.
  - Not affected by squash.
- **Without the macro:** the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- **csrrw, legal:** CSR 0x341 holds 0x80000000, i_src=0x1234, tag 5. Expect wb val 0x80000000 two cycles after accept. After commit of tag 5: one-cycle o_write, idx 0x341, val 0x1234.
- **csrrs / csrrc with x0:** i_rs1_zero=1 on 0x300. Expect wb of the old value, no o_write, and o_ready back without waiting for commit.
- **Illegal access:** i_read_illegal=1. Expect o_wb_illegal=1, o_wb_val=0, no write even after commit. Also csrrw to 0xF14 (read-only): illegal=1, no write.
- **Squash in WAIT_COMMIT:** squash before commit of tag 7. Expect no o_write and o_ready=1 the next cycle. A later commit of tag 7 has no effect.
- **Commit and squash in the same cycle (csrrc):** old=0xFF, imm=0x0F. Expect o_write val 0xF0.
- **Backpressure:** i_wb_ready low for 3 cycles. Expect o_wb_valid, val and tag held stable. With CSR_RMW_STALL_CNT_EN and i_valid held high throughout: the cycles with o_ready low are counted exactly.
